// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter and receiver:
// frame constants and the state encoding used by both FSMs.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Both FSMs walk IDLE -> START -> DATA(x8) -> STOP -> IDLE.
    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_START = 2'd1;
    localparam state_t S_DATA  = 2'd2;
    localparam state_t S_STOP  = 2'd3;

endpackage

// File: rtl/uart_if.sv
// Byte-stream and serial-line signals of the UART block.
// The slave modport is the UART itself; master is the host/line side.
interface uart_if;
    import uart_pkg::*;

    logic                 tx_dv;
    logic [DATA_BITS-1:0] tx_byte;
    logic                 tx;
    logic                 tx_busy;
    logic                 rx;
    logic                 rx_dv;
    logic [DATA_BITS-1:0] rx_byte;

    modport master (
        output tx_dv, tx_byte, rx,
        input  tx, tx_busy, rx_dv, rx_byte
    );

    modport slave (
        input  tx_dv, tx_byte, rx,
        output tx, tx_busy, rx_dv, rx_byte
    );

endinterface

// File: rtl/uart_rx.sv
// 8N1 deserialiser: synchronises the line, qualifies the start bit at its
// centre, then samples data and stop bits at their centres.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_i,
    output logic                 rx_dv_o,
    output logic [DATA_BITS-1:0] rx_byte_o
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 meta_q, sync_q;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 dv_q, dv_d;
    logic                 bit_done;

    assign bit_done  = (cnt_q == BIT_LAST);
    assign rx_dv_o   = dv_q;
    assign rx_byte_o = byte_q;

    // Returning to IDLE at the stop-bit centre lets a new start edge be caught in its second half.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sync_q == START_LVL) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (sync_q == START_LVL) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (sync_q == STOP_LVL) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q  <= STOP_LVL;
            sync_q  <= STOP_LVL;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            meta_q  <= rx_i;
            sync_q  <= meta_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serialiser: latches a byte on a one-cycle request and shifts it out
// LSB first, holding every bit for exactly CLKS_PER_BIT cycles.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_dv_i,
    input  logic [DATA_BITS-1:0] tx_byte_i,
    output logic                 tx_o,
    output logic                 tx_busy_o
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 bit_done;

    assign bit_done  = (cnt_q == BIT_LAST);
    assign tx_o      = tx_q;
    assign tx_busy_o = busy_q;

    // The line level for the next bit is loaded at the boundary, so tx stays registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (tx_dv_i) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    shift_d = tx_byte_i;
                    tx_d    = START_LVL;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                        tx_d    = STOP_LVL;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= STOP_LVL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing
// only the clock, reset and bit-rate parameters.
module uart_txrx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input logic   clk,
    input logic   reset,
    uart_if.slave bus
);

    uart_tx #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk       (clk),
        .reset     (reset),
        .tx_dv_i   (bus.tx_dv),
        .tx_byte_i (bus.tx_byte),
        .tx_o      (bus.tx),
        .tx_busy_o (bus.tx_busy)
    );

    uart_rx #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx_i      (bus.rx),
        .rx_dv_o   (bus.rx_dv),
        .rx_byte_o (bus.rx_byte)
    );

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx: loopback and directly driven rx frames,
// with received bytes checked against a queue of expected bytes.
module tb_uart_txrx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 115200;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic loopback = 1'b1;
    logic rxDrive  = 1'b1;

    int compared   = 0;
    int mismatched = 0;
    int rxCount    = 0;
    logic [7:0] expQ[$];

    uart_if bus();

    assign bus.rx = loopback ? bus.tx : rxDrive;

    uart_txrx #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every rx_dv strobe must match the oldest expected byte.
    always @(negedge clk) begin
        logic [7:0] want;
        if (bus.rx_dv === 1'b1) begin
            rxCount++;
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL rx_dv_unexpected: got byte %h, expected no strobe", bus.rx_byte);
            end else begin
                want = expQ.pop_front();
                if (bus.rx_byte !== want) begin
                    mismatched++;
                    $display("[TB] FAIL rx_byte: got %h, expected %h", bus.rx_byte, want);
                end
            end
        end
    end

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        bus.tx_dv   = 1'b1;
        bus.tx_byte = b;
        @(negedge clk);
        bus.tx_dv   = 1'b0;
    endtask

    task automatic waitRx(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rxCount >= target && bus.tx_busy === 1'b0) break;
        end
    endtask

    task automatic driveFrame(input logic [7:0] data, input logic stopLvl, input int stopCycles);
        rxDrive = START_LVL;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rxDrive = data[b];
            repeat (CPB) @(negedge clk);
        end
        rxDrive = stopLvl;
        repeat (stopCycles) @(negedge clk);
        rxDrive = 1'b1;
    endtask

    task automatic test_reset();
        bus.tx_dv   = 1'b0;
        bus.tx_byte = 8'h00;
        reset       = 1'b0;
        repeat (4) @(negedge clk);
        compared++;
        if (bus.tx !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_tx: got %b, expected 1", bus.tx); end
        compared++;
        if (bus.tx_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.tx_busy); end
        compared++;
        if (bus.rx_dv !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rx_dv: got %b, expected 0", bus.rx_dv); end
        compared++;
        if (bus.rx_byte !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_rx_byte: got %h, expected 00", bus.rx_byte); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_tx_waveform();
        logic [9:0] frame;
        int hits[10];
        int busyCycles;
        int firstDv;
        int base;
        frame      = {STOP_LVL, 8'h55, START_LVL};
        busyCycles = 0;
        firstDv    = -1;
        base       = rxCount;
        for (int b = 0; b < 10; b++) hits[b] = 0;
        loopback = 1'b1;
        expQ.push_back(8'h55);
        @(negedge clk);
        bus.tx_dv   = 1'b1;
        bus.tx_byte = 8'h55;
        @(negedge clk);
        bus.tx_dv   = 1'b0;
        for (int i = 0; i < 10 * CPB; i++) begin
            if (bus.tx === frame[i / CPB]) hits[i / CPB]++;
            if (bus.tx_busy === 1'b1) busyCycles++;
            if (bus.rx_dv === 1'b1 && firstDv < 0) firstDv = i;
            @(negedge clk);
        end
        for (int b = 0; b < 10; b++) begin
            compared++;
            if (hits[b] !== CPB) begin
                mismatched++;
                $display("[TB] FAIL tx_bit%0d: got %0d cycles at level %b, expected %0d", b, hits[b], frame[b], CPB);
            end
        end
        compared++;
        if (busyCycles !== 10 * CPB) begin mismatched++; $display("[TB] FAIL busy_len: got %0d, expected %0d", busyCycles, 10 * CPB); end
        compared++;
        if (bus.tx_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL busy_end: got %b, expected 0", bus.tx_busy); end
        compared++;
        if (bus.tx !== 1'b1) begin mismatched++; $display("[TB] FAIL tx_idle: got %b, expected 1", bus.tx); end
        compared++;
        if (firstDv < 2 + (19 * CPB) / 2 - 1 || firstDv > 2 + (19 * CPB) / 2 + 1) begin
            mismatched++;
            $display("[TB] FAIL rx_latency: got %0d, expected %0d +/-1", firstDv, 2 + (19 * CPB) / 2);
        end
        compared++;
        if (rxCount !== base + 1) begin mismatched++; $display("[TB] FAIL wave_rx_count: got %0d, expected %0d", rxCount, base + 1); end
    endtask

    task automatic test_loopback();
        logic [7:0] data[3];
        int target;
        data     = '{8'hAA, 8'h30, 8'h39};
        loopback = 1'b1;
        for (int k = 0; k < 3; k++) begin
            target = rxCount + 1;
            expQ.push_back(data[k]);
            sendByte(data[k]);
            waitRx(target, 24 * CPB);
            compared++;
            if (rxCount !== target) begin
                mismatched++;
                $display("[TB] FAIL loopback_%h: got %0d strobes, expected %0d", data[k], rxCount, target);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int target;
        loopback = 1'b1;
        target   = rxCount + 1;
        expQ.push_back(8'hA5);
        sendByte(8'hA5);
        repeat (3 * CPB) @(negedge clk);
        compared++;
        if (bus.tx_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL busy_mid: got %b, expected 1", bus.tx_busy); end
        sendByte(8'h12);
        waitRx(target, 24 * CPB);
        repeat (2 * CPB) @(negedge clk);
        compared++;
        if (rxCount !== target) begin mismatched++; $display("[TB] FAIL ignore_count: got %0d, expected %0d", rxCount, target); end
        compared++;
        if (bus.tx_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL ignore_busy: got %b, expected 0", bus.tx_busy); end
    endtask

    task automatic test_glitch();
        int base;
        loopback = 1'b0;
        rxDrive  = 1'b1;
        repeat (10) @(negedge clk);
        base    = rxCount;
        rxDrive = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rxDrive = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        compared++;
        if (rxCount !== base) begin mismatched++; $display("[TB] FAIL glitch_no_dv: got %0d, expected %0d", rxCount, base); end
        expQ.push_back(8'h3C);
        driveFrame(8'h3C, STOP_LVL, CPB);
        waitRx(base + 1, 2 * CPB);
        compared++;
        if (rxCount !== base + 1) begin mismatched++; $display("[TB] FAIL glitch_then_frame: got %0d, expected %0d", rxCount, base + 1); end
    endtask

    task automatic test_framing();
        int base;
        loopback = 1'b0;
        base     = rxCount;
        // Stop bit is low at its centre but released early, so the re-armed receiver sees only a glitch.
        driveFrame(8'h7E, ~STOP_LVL, (3 * CPB) / 4);
        repeat (2 * CPB) @(negedge clk);
        compared++;
        if (rxCount !== base) begin mismatched++; $display("[TB] FAIL framing_no_dv: got %0d, expected %0d", rxCount, base); end
        compared++;
        if (bus.rx_byte !== 8'h3C) begin mismatched++; $display("[TB] FAIL framing_hold: got %h, expected 3c", bus.rx_byte); end
    endtask

    task automatic test_reset_midframe();
        int target;
        loopback = 1'b1;
        sendByte(8'h5A);
        repeat (4 * CPB) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.tx !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_tx: got %b, expected 1", bus.tx); end
        compared++;
        if (bus.tx_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_busy: got %b, expected 0", bus.tx_busy); end
        compared++;
        if (bus.rx_dv !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_rx_dv: got %b, expected 0", bus.rx_dv); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        target = rxCount + 1;
        expQ.push_back(8'h81);
        sendByte(8'h81);
        waitRx(target, 24 * CPB);
        compared++;
        if (rxCount !== target) begin mismatched++; $display("[TB] FAIL midreset_loopback: got %0d, expected %0d", rxCount, target); end
    endtask

    initial begin
        test_reset();
        test_tx_waveform();
        test_loopback();
        test_ignore_busy();
        test_glitch();
        test_framing();
        test_reset_midframe();
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending bytes, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
